// File: rtl/mem_master.sv
// mem_master: splits one CPU word load/store into word_bytes byte transactions on
// the memory read/write/ready handshake, assembling loads little-endian.
module mem_master #(
  parameter int addr_width = 8,
  parameter int word_bytes = 2,
  parameter int timeout    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [addr_width-1:0]   cpu_addr,
  input  logic [8*word_bytes-1:0] cpu_wdata,
  input  logic                    cpu_read,
  input  logic                    cpu_write,
  output logic [8*word_bytes-1:0] cpu_rdata,
  output logic                    cpu_busy,
  output logic                    cpu_done,
  output logic                    cpu_error,
  output logic [addr_width-1:0]   mem_address,
  output logic [7:0]              mem_data_out,
  input  logic [7:0]              mem_data_in,
  output logic                    mem_read,
  output logic                    mem_write,
  input  logic                    mem_ready
);

  localparam int DW = 8 * word_bytes;
  localparam int IW = (word_bytes > 1) ? $clog2(word_bytes) : 1;
  localparam int CW = $clog2(timeout + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(word_bytes - 1);
  localparam logic [CW-1:0] TO_CNT   = CW'(timeout);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    GAP    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic                  is_read_q, is_read_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         idx_next;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         cnt_inc;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [addr_width-1:0] maddr_q, maddr_d;
  logic [7:0]            mdout_q, mdout_d;
  logic                  mrd_q, mrd_d;
  logic                  mwr_q, mwr_d;

  assign cpu_rdata    = rdata_q;
  assign cpu_busy     = busy_q;
  assign cpu_done     = done_q;
  assign cpu_error    = error_q;
  assign mem_address  = maddr_q;
  assign mem_data_out = mdout_q;
  assign mem_read     = mrd_q;
  assign mem_write    = mwr_q;

  // Next-state and next-output logic; every output is computed one cycle ahead.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    shadow_d  = shadow_q;
    rdata_d   = rdata_q;
    is_read_d = is_read_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    maddr_d   = maddr_q;
    mdout_d   = mdout_q;
    mrd_d     = mrd_q;
    mwr_d     = mwr_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    idx_next  = idx_q + IW'(1);
    cnt_inc   = cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (cpu_read ^ cpu_write) begin
          addr_d    = cpu_addr;
          wdata_d   = cpu_wdata;
          is_read_d = cpu_read;
          idx_d     = {IW{1'b0}};
          cnt_d     = {CW{1'b0}};
          maddr_d   = cpu_addr;
          mdout_d   = cpu_wdata[7:0];
          mrd_d     = cpu_read;
          mwr_d     = cpu_write;
          state_d   = ACCESS;
        end else if (cpu_read && cpu_write) begin
          done_d  = 1'b1;
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          if (is_read_q) begin
            shadow_d[{idx_q, 3'b000} +: 8] = mem_data_in;
          end else begin
            shadow_d = shadow_q;
          end
          cnt_d   = {CW{1'b0}};
          mrd_d   = 1'b0;
          mwr_d   = 1'b0;
          state_d = GAP;
        end else if (cnt_inc == TO_CNT) begin
          // Memory never answered this byte: abandon the word.
          cnt_d   = {CW{1'b0}};
          mrd_d   = 1'b0;
          mwr_d   = 1'b0;
          done_d  = 1'b1;
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      GAP: begin
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          error_d = 1'b0;
          if (is_read_q) begin
            rdata_d = shadow_q;
          end else begin
            rdata_d = rdata_q;
          end
          state_d = DONE;
        end else begin
          idx_d   = idx_next;
          maddr_d = addr_q + addr_width'(idx_next);
          mdout_d = wdata_q[{idx_next, 3'b000} +: 8];
          mrd_d   = is_read_q;
          mwr_d   = ~is_read_q;
          state_d = ACCESS;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        mrd_d   = 1'b0;
        mwr_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset clears everything including the load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= {addr_width{1'b0}};
      wdata_q   <= {DW{1'b0}};
      shadow_q  <= {DW{1'b0}};
      rdata_q   <= {DW{1'b0}};
      is_read_q <= 1'b0;
      idx_q     <= {IW{1'b0}};
      cnt_q     <= {CW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      maddr_q   <= {addr_width{1'b0}};
      mdout_q   <= 8'h00;
      mrd_q     <= 1'b0;
      mwr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      shadow_q  <= shadow_d;
      rdata_q   <= rdata_d;
      is_read_q <= is_read_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      maddr_q   <= maddr_d;
      mdout_q   <= mdout_d;
      mrd_q     <= mrd_d;
      mwr_q     <= mwr_d;
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master: byte-wide memory model with programmable ready
// delay, scoreboard queues for byte transactions and word completions.
module tb_mem_master;

  logic        clk;
  logic        reset;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_read;
  logic        cpu_write;
  logic [15:0] cpu_rdata;
  logic        cpu_busy;
  logic        cpu_done;
  logic        cpu_error;
  logic [7:0]  mem_address;
  logic [7:0]  mem_data_out;
  logic [7:0]  mem_data_in;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ready;

  mem_master #(.addr_width(8), .word_bytes(2), .timeout(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_error(cpu_error),
    .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready)
  );

  typedef struct {logic wr; logic [7:0] addr; logic [7:0] data;} txn_t;
  typedef struct {logic err; logic [15:0] rdata; int cyc;} exp_t;

  txn_t       txn_q[$];
  exp_t       exp_q[$];
  logic [7:0] mem [256];
  int         n_total;
  int         n_pass;
  int         cyc;
  int         k_delay;
  logic       ready_en;
  int         rd_cyc;
  int         wr_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic mem_monitor();
    int   scnt;
    txn_t t;
    scnt = 0;
    forever begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        if (mem_read) rd_cyc++;
        if (mem_write) wr_cyc++;
        check("one_strobe", 32'(mem_read & mem_write), 32'd0);
        scnt++;
        if (ready_en && scnt == k_delay) begin
          mem_ready = 1'b1;
          if (txn_q.size() == 0) begin
            check("spurious_txn", 32'd1, 32'd0);
          end else begin
            t = txn_q.pop_front();
            check("txn_op", 32'(mem_write), 32'(t.wr));
            check("txn_addr", 32'(mem_address), 32'(t.addr));
            if (t.wr) check("txn_wdata", 32'(mem_data_out), 32'(t.data));
          end
          if (mem_write) mem[mem_address] = mem_data_out;
          else mem_data_in = mem[mem_address];
        end else begin
          mem_ready = 1'b0;
        end
      end else begin
        scnt = 0;
        mem_ready = 1'b0;
      end
    end
  endtask

  task automatic done_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (cpu_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'(cpu_done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("done_error", 32'(cpu_error), 32'(e.err));
          check("done_rdata", 32'(cpu_rdata), 32'(e.rdata));
          check("busy_in_done", 32'(cpu_busy), 32'd1);
        end
      end
    end
  endtask

  task automatic push_word(input logic wr, input logic [7:0] addr, input logic [15:0] wd);
    txn_t t;
    for (int i = 0; i < 2; i++) begin
      t.wr   = wr;
      t.addr = addr + 8'(i);
      t.data = wd[8*i +: 8];
      txn_q.push_back(t);
    end
  endtask

  task automatic do_op(input logic rd, input logic wr, input logic [7:0] addr,
                       input logic [15:0] wd, input int k, input logic e_err,
                       input logic [15:0] e_rd, input int lat);
    exp_t e;
    k_delay = k;
    if ((rd ^ wr) && ready_en) push_word(wr, addr, wd);
    @(negedge clk);
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = addr;
    cpu_wdata = wd;
    e.err   = e_err;
    e.rdata = e_rd;
    e.cyc   = cyc + lat;
    exp_q.push_back(e);
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) begin
      @(negedge clk);
      #1;
    end
    check("done_seen", exp_q.size(), 32'd0);
    exp_q.delete();
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    check("txn_drained", txn_q.size(), 32'd0);
    txn_q.delete();
    @(negedge clk);
  endtask

  initial begin
    int rd0;
    int wr0;
    int t0;
    n_total = 0;
    n_pass = 0;
    rd_cyc = 0;
    wr_cyc = 0;
    k_delay = 2;
    ready_en = 1'b1;
    reset = 1'b1;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_addr = 8'h00;
    cpu_wdata = 16'h0000;
    mem_ready = 1'b0;
    mem_data_in = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'hFF] = 8'h34;
    mem[8'h00] = 8'h12;
    fork
      mem_monitor();
      done_monitor();
    join_none

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(cpu_busy), 32'd0);
    check("rst_done", 32'(cpu_done), 32'd0);
    check("rst_error", 32'(cpu_error), 32'd0);
    check("rst_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Store 0xBEEF @0x10, delay 2: done at T0+7
    do_op(1'b0, 1'b1, 8'h10, 16'hBEEF, 2, 1'b0, 16'h0000, 7);
    check("mem_10", 32'(mem[8'h10]), 32'hEF);
    check("mem_11", 32'(mem[8'h11]), 32'hBE);

    // Load it back: read strobes only
    wr0 = wr_cyc;
    do_op(1'b1, 1'b0, 8'h10, 16'h0000, 2, 1'b0, 16'hBEEF, 7);
    check("load_no_write", wr_cyc - wr0, 32'd0);

    // Wrap-around load 0xFF -> 0x00, delay 1
    do_op(1'b1, 1'b0, 8'hFF, 16'h0000, 1, 1'b0, 16'h1234, 5);

    // Memory never ready: timeout error at T0+17, rdata kept
    ready_en = 1'b0;
    do_op(1'b1, 1'b0, 8'h40, 16'h0000, 2, 1'b1, 16'h1234, 17);
    ready_en = 1'b1;

    // Normal traffic afterwards, other delays
    do_op(1'b0, 1'b1, 8'h20, 16'hA55A, 1, 1'b0, 16'h1234, 5);
    do_op(1'b1, 1'b0, 8'h20, 16'h0000, 3, 1'b0, 16'hA55A, 9);

    // Both requests: error at T0+1, no strobes
    rd0 = rd_cyc;
    wr0 = wr_cyc;
    do_op(1'b1, 1'b1, 8'h30, 16'h1111, 2, 1'b1, 16'hA55A, 1);
    check("illegal_no_rd", rd_cyc - rd0, 32'd0);
    check("illegal_no_wr", wr_cyc - wr0, 32'd0);

    // Reset during the second byte's ACCESS
    k_delay = 2;
    push_word(1'b0, 8'h10, 16'h0000);
    void'(txn_q.pop_back());
    @(negedge clk);
    t0 = cyc;
    cpu_read = 1'b1;
    cpu_addr = 8'h10;
    while (cyc < t0 + 4) @(negedge clk);
    check("mid_second_read", 32'(mem_read), 32'd1);
    check("mid_second_addr", 32'(mem_address), 32'h11);
    reset = 1'b1;
    cpu_read = 1'b0;
    @(negedge clk);
    #1;
    check("rstmid_strobes", 32'({mem_read, mem_write}), 32'd0);
    check("rstmid_busy", 32'(cpu_busy), 32'd0);
    check("rstmid_done", 32'(cpu_done), 32'd0);
    check("rstmid_rdata", 32'(cpu_rdata), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("rstmid_idle", 32'(cpu_busy), 32'd0);
    check("rstmid_txn", txn_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
